// File: rtl/sp_ram_be_clr.sv
// ---------------------------------------------------------------------------
// sp_ram_be_clr
//
// Single-port synchronous RAM with per-lane byte enables, a selectable
// read-during-write behaviour, a read-data valid strobe and a hardware clear
// engine. The clear engine sweeps zeros through every word after reset and
// whenever clr is pulsed. While it runs, busy is high and accesses are dropped.
//
// Optional feature (compile-time macro):
//   OUTPUT_REG_EN  - adds a second output register stage. Read latency becomes
//                    2 cycles and valid is delayed to stay aligned with
//                    data_out.
//
// Parameters:
//   data_width  word width in bits (integer multiple of lane_width)
//   addr_width  address width; depth = 2**addr_width words
//   lane_width  bits covered by one byte-enable lane
//   read_mode   0 = read-first (old word), 1 = write-first (merged new word)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   access request
//   we        in   write qualifier for an accepted access
//   be        in   lane write enables, bit i covers data_in[i*lane_width +: lane_width]
//   addr      in   word address
//   data_in   in   write data
//   clr       in   one-cycle request to start a clear sweep
//   busy      out  clear sweep in progress
//   data_out  out  registered read data
//   valid     out  data_out updated by an accepted access
// ---------------------------------------------------------------------------
module sp_ram_be_clr #(
    parameter int data_width = 32,
    parameter int addr_width = 4,
    parameter int lane_width = 8,
    parameter int read_mode  = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic                               we,
    input  logic [data_width/lane_width-1:0]   be,
    input  logic [addr_width-1:0]              addr,
    input  logic [data_width-1:0]              data_in,
    input  logic                               clr,
    output logic                               busy,
    output logic [data_width-1:0]              data_out,
    output logic                               valid
);

    localparam int lanes = data_width / lane_width;
    localparam int depth = 2 ** addr_width;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [addr_width-1:0]  ptr;
    logic [addr_width-1:0]  ptr_next;

    logic [data_width-1:0]  mem [depth];

    logic                   accept;
    logic [data_width-1:0]  old_word;
    logic [data_width-1:0]  merged_word;
    logic [data_width-1:0]  read_word;

    logic [data_width-1:0]  rd_data;
    logic                   rd_valid;

    assign busy     = (state == CLEAR);
    assign accept   = en && !busy;
    assign old_word = mem[addr];

    // Build the post-write word lane by lane; a read (we=0) leaves it equal
    // to the stored word, so the same value serves both access kinds.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < lanes; i++) begin
            if (we && be[i]) begin
                merged_word[i*lane_width +: lane_width] = data_in[i*lane_width +: lane_width];
            end
        end
        read_word = (read_mode == 1) ? merged_word : old_word;
    end

    // Clear-engine state register. Reset lands in CLEAR with ptr=0 so that a
    // full sweep starts automatically on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Sweep sequencing: ptr walks every word once, wrapping to 0 on the last
    // word so the next sweep starts at the bottom. clr during a sweep is ignored.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            CLEAR: begin
                ptr_next = ptr + addr_width'(1);
                if (ptr == addr_width'(depth - 1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // Storage array is not reset; only the sweep zeroes it. The sweep owns
    // the write port while busy, which is also when accesses are refused.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr] <= '0;
        end else if (accept && we) begin
            mem[addr] <= merged_word;
        end
    end

    // First output stage: data_out holds between accepted accesses,
    // valid pulses once per accepted access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= accept;
            if (accept) begin
                rd_data <= read_word;
            end
        end
    end

`ifdef OUTPUT_REG_EN
    logic [data_width-1:0]  out_data;
    logic                   out_valid;

    // Second output stage loads every cycle, so it delays data and valid
    // together and keeps full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= rd_data;
            out_valid <= rd_valid;
        end
    end

    assign data_out = out_data;
    assign valid    = out_valid;
`else
    assign data_out = rd_data;
    assign valid    = rd_valid;
`endif

endmodule

// File: tb/tb_sp_ram_be_clr.sv
// ---------------------------------------------------------------------------
// tb_sp_ram_be_clr
//
// Drives two instances of sp_ram_be_clr (read-first and write-first) with the
// same stimulus. A word-array reference model predicts each returned word and
// pushes it into a per-instance queue; a monitor pops and compares whenever
// an instance raises valid, and checks that data_out holds otherwise.
// Build with +define+OUTPUT_REG_EN to exercise the two-stage output.
// ---------------------------------------------------------------------------
module tb_sp_ram_be_clr;

`ifdef OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [31:0] data;
        int          stamp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] data_in;
    logic        clr;

    logic        busy0;
    logic        busy1;
    logic [31:0] data_out0;
    logic [31:0] data_out1;
    logic        valid0;
    logic        valid1;

    int          checks;
    int          failures;
    int          cycle_cnt;
    int          sweep_left;
    logic [31:0] ref_mem [16];
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] last0;
    logic [31:0] last1;

    sp_ram_be_clr #(.data_width(32), .addr_width(4), .lane_width(8), .read_mode(0)) dut_rf (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr),
        .data_in(data_in), .clr(clr), .busy(busy0), .data_out(data_out0), .valid(valid0)
    );

    sp_ram_be_clr #(.data_width(32), .addr_width(4), .lane_width(8), .read_mode(1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .be(be), .addr(addr),
        .data_in(data_in), .clr(clr), .busy(busy1), .data_out(data_out1), .valid(valid1)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle stamp advanced away from the active edge so both the driver and
    // the monitor read a stable value around each rising edge.
    always @(negedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mergeLanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] lane_en);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

    // A sweep leaves every word zero and refuses accesses for 16 edges, so
    // the model zeroes its image up front and just counts the busy edges.
    task automatic startSweep();
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        sweep_left = 16;
    endtask

    // Drives one cycle of inputs (called just after a falling edge), updates
    // the model at the rising edge and checks busy shortly after it.
    task automatic applyStimulus(input logic e, input logic w, input logic [3:0] b,
                                 input logic [3:0] a, input logic [31:0] d, input logic c);
        logic [31:0] old_w;
        logic [31:0] new_w;
        exp_t        item;
        en      = e;
        we      = w;
        be      = b;
        addr    = a;
        data_in = d;
        clr     = c;
        @(posedge clk);
        if (sweep_left > 0) begin
            sweep_left--;
        end else begin
            if (e) begin
                old_w      = ref_mem[a];
                new_w      = mergeLanes(old_w, d, w ? b : 4'h0);
                item.stamp = cycle_cnt;
                item.data  = old_w;
                q0.push_back(item);
                item.data  = new_w;
                q1.push_back(item);
                if (w) ref_mem[a] = new_w;
            end
            if (c) startSweep();
        end
        #1;
        checkOutput("busy_rf", {31'b0, busy0}, {31'b0, sweep_left > 0});
        checkOutput("busy_wf", {31'b0, busy1}, {31'b0, sweep_left > 0});
        @(negedge clk);
        en  = 1'b0;
        we  = 1'b0;
        clr = 1'b0;
    endtask

    // Asserts reset at a falling edge, checks the reset outputs at once,
    // holds for a few cycles and releases at a falling edge.
    task automatic doReset(input int hold);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy_rf",  {31'b0, busy0},  32'h1);
        checkOutput("rst_busy_wf",  {31'b0, busy1},  32'h1);
        checkOutput("rst_valid_rf", {31'b0, valid0}, 32'h0);
        checkOutput("rst_valid_wf", {31'b0, valid1}, 32'h0);
        checkOutput("rst_data_rf",  data_out0,       32'h0);
        checkOutput("rst_data_wf",  data_out1,       32'h0);
        q0.delete();
        q1.delete();
        last0 = 32'h0;
        last1 = 32'h0;
        startSweep();
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic readAll();
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 4'h0, 4'(i), $urandom, 1'b0);
    endtask

    // Monitor: pops one expectation per valid pulse, checks order, latency
    // and value; between pulses data_out must hold the last returned word.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (valid0) begin
                if (q0.size() == 0) begin
                    checkOutput("unexpected_valid_rf", {31'b0, valid0}, 32'h0);
                end else begin
                    e = q0.pop_front();
                    checkOutput("data_rf", data_out0, e.data);
                    checkOutput("latency_rf", cycle_cnt - e.stamp, LAT - 1);
                    last0 = e.data;
                end
            end else begin
                checkOutput("hold_rf", data_out0, last0);
            end
            if (valid1) begin
                if (q1.size() == 0) begin
                    checkOutput("unexpected_valid_wf", {31'b0, valid1}, 32'h0);
                end else begin
                    e = q1.pop_front();
                    checkOutput("data_wf", data_out1, e.data);
                    checkOutput("latency_wf", cycle_cnt - e.stamp, LAT - 1);
                    last1 = e.data;
                end
            end else begin
                checkOutput("hold_wf", data_out1, last1);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        cycle_cnt = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        we        = 1'b0;
        be        = 4'h0;
        addr      = 4'h0;
        data_in   = 32'h0;
        clr       = 1'b0;
        last0     = 32'h0;
        last1     = 32'h0;
        startSweep();

        @(negedge clk);
        $display("[TB] reset sweep");
        doReset(3);
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, 4'h0, 4'(k), 32'h0, 1'b0);
        readAll();

        $display("[TB] byte-enable merge");
        applyStimulus(1'b1, 1'b1, 4'hF,    4'd3, 32'hA5A5A5A5, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0,    4'd3, 32'h0,        1'b0);
        checkOutput("merge_model", ref_mem[3], 32'hA522A544);

        $display("[TB] read-during-write");
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd1, 32'h00000056, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd1, 32'hB4B4B4B4, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'h0, 4'd1, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd1, 32'h0,        1'b0);

        $display("[TB] back-to-back reads");
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd0, 32'h000000A5, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd1, 32'h00000056, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd2, 32'h000000B4, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd1, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'd2, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);

        $display("[TB] clear on request");
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b1, 4'hF, 4'(k), 32'hFFFFFFFF, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k == 3)      applyStimulus(1'b1, 1'b1, 4'hF, 4'd5, 32'h12345678, 1'b0);
            else if (k == 7) applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
            else             applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        end
        readAll();

        $display("[TB] randomized traffic");
        for (int k = 0; k < 300; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 4'($urandom),
                          $urandom, $urandom_range(0, 49) == 0);
        end

        $display("[TB] reset mid-sweep");
        while (sweep_left > 0) applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'd9, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 4'h0, 4'(k), 32'h0, 1'b0);
        doReset(2);
        for (int k = 0; k < 17; k++) applyStimulus(1'b1, 1'b0, 4'h0, 4'(k), 32'h0, 1'b0);
        readAll();

        repeat (4) applyStimulus(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
        checkOutput("drain_rf", q0.size(), 32'h0);
        checkOutput("drain_wf", q1.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sp_ram_be_clr.md
# sp_ram_be_clr

Parametrised single-port synchronous RAM with per-lane byte enables, selectable read-during-write mode, a read-data valid strobe, and a hardware clear engine. The clear engine zeroes every word after reset and on request. It replaces the plain single-port data memory (clk/we/addr/data_in/data_out) wherever a datapath needs partial-word writes or a known-zero memory image without a software init loop.

## Interface
- data_width, 32, word width in bits; must be an integer multiple of lane_width
- addr_width, 4, address width; depth = 2**addr_width words
- lane_width, 8, bits per byte-enable lane; lanes = data_width/lane_width
- read_mode, 0, read-during-write behaviour: 0 = read-first (old word), 1 = write-first (merged new word)

- clk  input  1  single clock; all logic rising-edge
- rst_n  input  1  reset, asynchronous assert, active-low
- en  input  1  access request; sampled on the clk edge
- we  input  1  write qualifier for an accepted access
- be  input  lanes  lane write enables; bit i covers data_in[i*lane_width +: lane_width]
- addr  input  addr_width  word address
- data_in  input  data_width  write data
- clr  input  1  one-cycle request to start a clear sweep
- busy  output  1  clear sweep in progress; accesses are ignored
- data_out  output  data_width  registered read data
- valid  output  1  data_out updated by an accepted access this cycle

## Operation
- An access is accepted on a clk edge when en=1 and busy=0. An access with en=1 while busy=1 is dropped silently: no write, no valid.
- Write: accepted access with we=1. Lanes with be[i]=1 take data_in. Lanes with be[i]=0 keep their old contents. we=1 with be=0 writes nothing but still returns data.
- Every accepted access, read or write, returns data at addr:
  - read_mode 0: the pre-write word.
  - read_mode 1: the post-write merged word.
- data_out holds its last value when no access is accepted. valid is a one-cycle pulse per accepted access.
- Clear FSM, two states:
  - CLEAR: writes 0 to word ptr each cycle and increments ptr. The cycle that writes ptr=depth-1 transitions to IDLE, and ptr wraps to 0.
  - IDLE: clr=1 moves to CLEAR with ptr=0.
  - clr while in CLEAR is ignored; the sweep does not restart.
- Reset:
  - rst_n=0 forces state CLEAR and ptr=0, which is the async reset state. On release, the sweep runs automatically.
  - rst_n=0 mid-sweep restarts the sweep from word 0 after release.
- Memory contents are not reset directly; they are only zeroed by the sweep.
- Reset values: busy=1, valid=0, data_out=0, all pipeline registers 0.

## Timing
- busy = (state==CLEAR), driven from the state register.
- A full sweep takes exactly depth cycles; busy falls on the edge after word depth-1 is written. Default depth 16 gives 16 busy cycles after rst_n release.
- A clr accepted at edge N sets busy high after edge N. An access presented at edge N itself, with busy=0 and en=1, is still accepted.
- Read latency is 1 cycle: an access accepted at edge N updates data_out and sets valid after edge N.
- Back-to-back accesses give one result per cycle at full throughput.
- Write then read of the same addr on consecutive cycles returns the written data in both read modes.

## Configuration
- OUTPUT_REG_EN defined:
  - Adds a second output register stage; read latency 2 cycles.
  - valid is delayed identically and stays aligned with data_out.
  - The stage resets to 0.
  - Throughput stays at one result per cycle.
- OUTPUT_REG_EN undefined: latency 1 as described in Timing.

## Test plan
Defaults unless stated: data_width 32, addr_width 4, lane_width 8, read_mode 0.
- Reset sweep: release rst_n, then hold en=1 with we=0 during the sweep. Required: busy=1 for 16 cycles, valid=0 throughout, and reads of addr 0–15 afterwards all return 0x00000000.
- Byte-enable merge: write 0xA5A5A5A5 with be=4'hF at addr 3, then write 0x11223344 with be=4'b0101 at addr 3, then read addr 3. Required: 0xA522A544.
- Read-during-write, addr 1 holding 0x00000056, write 0xB4B4B4B4 with be=4'hF:
  - read_mode 0 returns data_out=0x00000056 with valid=1 one cycle later.
  - read_mode 1 returns 0xB4B4B4B4.
- Clear on request:
  - Fill addr 0–15 with 0xFFFFFFFF.
  - Pulse clr. busy=1 for exactly 16 cycles; a write issued mid-sweep is dropped.
  - A second clr pulse at sweep cycle 8 does not extend busy.
  - All words read 0 afterwards.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 5. Required: outputs return to reset values immediately, and after release busy=1 for a full 16 cycles.
- OUTPUT_REG_EN defined, back-to-back reads of addr 0,1,2 holding 0xA5, 0x56, 0xB4. Required: valid high on cycles 2,3,4 after the first accept, with data 0x000000A5, 0x00000056, 0x000000B4 in order.
